bp_cce_inst_fetch: RTL and testbench

Microcode fetch unit for the CCE. It holds the CCE instruction RAM and the program counter, and presents one instruction per cycle to the decode/execute path. The stall unit's output feeds back into this block. On a stall it replays the current instruction, and on a taken branch it redirects the PC. It also services configuration-bus reads and writes of the instruction RAM while the CCE is in uncached (init) mode.

---
 rtl/bp_cce_inst_fetch.sv | 130 +++++++++++++
 tb/tb_bp_cce_inst_fetch.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cce_inst_fetch.sv
// CCE microcode fetch unit: owns the instruction RAM and the PC, presents one
// instruction per cycle in normal mode, and serves config-bus RAM accesses
// while the CCE is in uncached/init mode.
module bp_cce_inst_fetch #(
    parameter int num_instr_els = 256,
    parameter int pc_width      = $clog2(num_instr_els),
    parameter int instr_width   = 48
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   cce_mode_i,
    input  logic                   cfg_w_v_i,
    input  logic                   cfg_r_v_i,
    input  logic [pc_width-1:0]    cfg_addr_i,
    input  logic [instr_width-1:0] cfg_data_i,
    output logic [instr_width-1:0] cfg_data_o,
    output logic                   cfg_data_v_o,
    input  logic                   stall_i,
    input  logic                   redirect_v_i,
    input  logic [pc_width-1:0]    redirect_pc_i,
    output logic [instr_width-1:0] inst_o,
    output logic                   inst_v_o,
    output logic [pc_width-1:0]    pc_o
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e state_r, state_n;

    // Single-port instruction store; contents survive reset.
    logic [instr_width-1:0] mem [num_instr_els];

    logic [pc_width-1:0] next_pc;
    logic [pc_width-1:0] rd_addr_p0;
    logic [pc_width-1:0] pc_n;
    logic                ram_we;
    logic                inst_load;
    logic                vld_p0;
    logic                cfg_rd_fire;

    // Next-PC priority: stall replays, then branch target, then sequential (wraps).
    always_comb begin
        next_pc = pc_o + pc_width'(1);
        if (stall_i)
            next_pc = pc_o;
        else if (redirect_v_i)
            next_pc = redirect_pc_i;
    end

    // Next-state and single RAM port arbitration between config and fetch.
    always_comb begin
        state_n     = state_r;
        rd_addr_p0  = cfg_addr_i;
        ram_we      = 1'b0;
        cfg_rd_fire = 1'b0;
        inst_load   = 1'b0;
        vld_p0      = 1'b0;
        pc_n        = '0;

        case (state_r)
            ST_INIT: begin
                // A write wins over a simultaneous read; the read is dropped.
                ram_we      = cfg_w_v_i;
                cfg_rd_fire = cfg_r_v_i & ~cfg_w_v_i;
                if (cce_mode_i && !cfg_w_v_i && !cfg_r_v_i)
                    state_n = ST_FETCH;
            end
            ST_FETCH: begin
                rd_addr_p0 = '0;
                inst_load  = 1'b1;
                vld_p0     = 1'b1;
                pc_n       = '0;
                state_n    = ST_RUN;
            end
            ST_RUN: begin
                // Leaving run mode only once the stall has cleared; the
                // instruction on the outputs simply stays there, unqualified.
                if (!cce_mode_i && !stall_i) begin
                    state_n = ST_INIT;
                end else begin
                    rd_addr_p0 = next_pc;
                    inst_load  = 1'b1;
                    vld_p0     = 1'b1;
                    pc_n       = next_pc;
                end
            end
            default: begin
                state_n = ST_INIT;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            state_r <= ST_INIT;
        else
            state_r <= state_n;
    end

    // RAM write port, only reachable from init mode.
    always_ff @(posedge clk_i) begin
        if (ram_we)
            mem[cfg_addr_i] <= cfg_data_i;
    end

    // Registered RAM read: fetch output and config read response.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            inst_o       <= '0;
            inst_v_o     <= 1'b0;
            pc_o         <= '0;
            cfg_data_o   <= '0;
            cfg_data_v_o <= 1'b0;
        end else begin
            inst_v_o     <= vld_p0;
            pc_o         <= pc_n;
            cfg_data_v_o <= cfg_rd_fire;
            if (inst_load)
                inst_o <= mem[rd_addr_p0];
            if (cfg_rd_fire)
                cfg_data_o <= mem[rd_addr_p0];
        end
    end

endmodule

// File: tb/tb_bp_cce_inst_fetch.sv
// Testbench for bp_cce_inst_fetch: directed stimulus, a behavioural model
// checked every cycle, plus hand-computed literal expectations.
module tb_bp_cce_inst_fetch;

    localparam int N  = 256;
    localparam int PW = 8;
    localparam int IW = 48;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b1;
    logic          cce_mode_i = 1'b0;
    logic          cfg_w_v_i = 1'b0;
    logic          cfg_r_v_i = 1'b0;
    logic [PW-1:0] cfg_addr_i = '0;
    logic [IW-1:0] cfg_data_i = '0;
    logic [IW-1:0] cfg_data_o;
    logic          cfg_data_v_o;
    logic          stall_i = 1'b0;
    logic          redirect_v_i = 1'b0;
    logic [PW-1:0] redirect_pc_i = '0;
    logic [IW-1:0] inst_o;
    logic          inst_v_o;
    logic [PW-1:0] pc_o;

    int checks = 0;
    int fails  = 0;

    bp_cce_inst_fetch #(
        .num_instr_els (N),
        .pc_width      (PW),
        .instr_width   (IW)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .cce_mode_i    (cce_mode_i),
        .cfg_w_v_i     (cfg_w_v_i),
        .cfg_r_v_i     (cfg_r_v_i),
        .cfg_addr_i    (cfg_addr_i),
        .cfg_data_i    (cfg_data_i),
        .cfg_data_o    (cfg_data_o),
        .cfg_data_v_o  (cfg_data_v_o),
        .stall_i       (stall_i),
        .redirect_v_i  (redirect_v_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_o        (inst_o),
        .inst_v_o      (inst_v_o),
        .pc_o          (pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: RAM image, run phase, expected outputs.
    logic [IW-1:0] ram_m [N];
    bit            known [N];
    int            phase = 0;          // 0 = init, 1 = boot pending, 2 = running
    logic [PW-1:0] m_pc = '0;
    bit            m_v = 1'b0;
    bit            m_cv = 1'b0;
    logic [IW-1:0] m_inst = '0;
    bit            m_ik = 1'b1;
    logic [IW-1:0] m_cdata = '0;

    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            phase = 0; m_pc = '0; m_v = 1'b0; m_cv = 1'b0;
            m_inst = '0; m_ik = 1'b1; m_cdata = '0;
        end else if (phase == 0) begin
            m_cv = cfg_r_v_i && !cfg_w_v_i;
            if (m_cv) m_cdata = ram_m[cfg_addr_i];
            if (cfg_w_v_i) begin
                ram_m[cfg_addr_i] = cfg_data_i;
                known[cfg_addr_i] = 1'b1;
            end
            if (cce_mode_i && !cfg_w_v_i && !cfg_r_v_i) phase = 1;
        end else if (phase == 1) begin
            phase = 2; m_pc = '0; m_v = 1'b1; m_cv = 1'b0;
            m_inst = ram_m[0]; m_ik = known[0];
        end else begin
            m_cv = 1'b0;
            if (!cce_mode_i && !stall_i) begin
                phase = 0; m_v = 1'b0; m_pc = '0;
            end else begin
                if (!stall_i) begin
                    if (redirect_v_i) m_pc = redirect_pc_i;
                    else              m_pc = PW'((int'(m_pc) + 1) % N);
                end
                m_inst = ram_m[m_pc];
                m_ik   = known[m_pc];
            end
        end
    end

    // Per-cycle comparison against the model, sampled after the edge settles.
    always @(posedge clk_i) begin
        #2;
        check("inst_v", 64'(inst_v_o), 64'(m_v));
        check("pc", 64'(pc_o), 64'(m_pc));
        check("cfg_v", 64'(cfg_data_v_o), 64'(m_cv));
        check("cfg_data", 64'(cfg_data_o), 64'(m_cdata));
        if (m_ik) check("inst", 64'(inst_o), 64'(m_inst));
    end

    task automatic cfg_write(input logic [PW-1:0] a, input logic [IW-1:0] d);
        cfg_w_v_i = 1'b1; cfg_addr_i = a; cfg_data_i = d;
        @(negedge clk_i);
        cfg_w_v_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_inst_v", 64'(inst_v_o), 64'(0));
        check("rst_pc", 64'(pc_o), 64'(0));
        check("rst_inst", 64'(inst_o), 64'(0));
        check("rst_cfg_v", 64'(cfg_data_v_o), 64'(0));
        reset_n_i = 1'b1;

        // Load RAM: 0..3 = A0..A3, 4..7 = B4..B7, 255 = FF
        for (int i = 0; i < 8; i++)
            cfg_write(PW'(i), (i < 4) ? IW'(32'hA0 + i) : IW'(32'hB0 + i));
        cfg_write(PW'(255), IW'(48'hFF));

        // Readback of address 2 with one-cycle latency
        cfg_r_v_i = 1'b1; cfg_addr_i = PW'(2);
        @(negedge clk_i);
        cfg_r_v_i = 1'b0;
        check("rd2_v", 64'(cfg_data_v_o), 64'(1));
        check("rd2_data", 64'(cfg_data_o), 64'(48'hA2));
        @(negedge clk_i);
        check("rd2_pulse_end", 64'(cfg_data_v_o), 64'(0));

        // Simultaneous write and read of address 5
        cfg_w_v_i = 1'b1; cfg_r_v_i = 1'b1; cfg_addr_i = PW'(5); cfg_data_i = IW'(48'hC5);
        @(negedge clk_i);
        cfg_w_v_i = 1'b0; cfg_r_v_i = 1'b0;
        check("wr_rd_no_v", 64'(cfg_data_v_o), 64'(0));
        cfg_r_v_i = 1'b1;
        @(negedge clk_i);
        cfg_r_v_i = 1'b0;
        check("rd5_v", 64'(cfg_data_v_o), 64'(1));
        check("rd5_data", 64'(cfg_data_o), 64'(48'hC5));

        // Boot: valid two cycles after mode rises
        cce_mode_i = 1'b1;
        @(negedge clk_i);
        check("boot_fetch_v", 64'(inst_v_o), 64'(0));
        @(negedge clk_i);
        check("boot_v", 64'(inst_v_o), 64'(1));
        check("boot_pc", 64'(pc_o), 64'(0));
        check("boot_inst", 64'(inst_o), 64'(48'hA0));
        @(negedge clk_i);
        check("seq_pc1", 64'(pc_o), 64'(1));
        check("seq_inst1", 64'(inst_o), 64'(48'hA1));
        @(negedge clk_i);
        check("seq_pc2", 64'(pc_o), 64'(2));
        check("seq_inst2", 64'(inst_o), 64'(48'hA2));

        // Stall for three cycles at pc 2, redirect ignored during stall
        stall_i = 1'b1; redirect_v_i = 1'b1; redirect_pc_i = PW'(7);
        @(negedge clk_i);
        check("stall_pc_a", 64'(pc_o), 64'(2));
        check("stall_inst_a", 64'(inst_o), 64'(48'hA2));
        redirect_v_i = 1'b0;
        @(negedge clk_i);
        check("stall_pc_b", 64'(pc_o), 64'(2));
        @(negedge clk_i);
        check("stall_pc_c", 64'(pc_o), 64'(2));
        check("stall_inst_c", 64'(inst_o), 64'(48'hA2));
        stall_i = 1'b0;
        @(negedge clk_i);
        check("post_stall_pc", 64'(pc_o), 64'(3));
        check("post_stall_inst", 64'(inst_o), 64'(48'hA3));

        // Redirect to the last address and wrap; config write in run is ignored
        redirect_v_i = 1'b1; redirect_pc_i = PW'(255);
        cfg_w_v_i = 1'b1; cfg_addr_i = PW'(1); cfg_data_i = IW'(48'hEE);
        @(negedge clk_i);
        redirect_v_i = 1'b0; cfg_w_v_i = 1'b0;
        check("redir_pc", 64'(pc_o), 64'(255));
        check("redir_inst", 64'(inst_o), 64'(48'hFF));
        cfg_r_v_i = 1'b1;
        @(negedge clk_i);
        cfg_r_v_i = 1'b0;
        check("wrap_pc", 64'(pc_o), 64'(0));
        check("wrap_inst", 64'(inst_o), 64'(48'hA0));
        check("run_rd_ignored", 64'(cfg_data_v_o), 64'(0));
        @(negedge clk_i);
        check("run_wr_ignored", 64'(inst_o), 64'(48'hA1));

        // Mode drop while stalled keeps replaying
        cce_mode_i = 1'b0; stall_i = 1'b1;
        @(negedge clk_i);
        check("exit_stall_v_a", 64'(inst_v_o), 64'(1));
        check("exit_stall_pc_a", 64'(pc_o), 64'(1));
        @(negedge clk_i);
        check("exit_stall_v_b", 64'(inst_v_o), 64'(1));
        check("exit_stall_inst_b", 64'(inst_o), 64'(48'hA1));
        stall_i = 1'b0;
        @(negedge clk_i);
        check("exit_v", 64'(inst_v_o), 64'(0));
        check("exit_pc", 64'(pc_o), 64'(0));
        cfg_r_v_i = 1'b1; cfg_addr_i = PW'(1);
        @(negedge clk_i);
        cfg_r_v_i = 1'b0;
        check("rd1_after_run_v", 64'(cfg_data_v_o), 64'(1));
        check("rd1_after_run", 64'(cfg_data_o), 64'(48'hA1));

        // Reboot, then asynchronous reset between edges
        cce_mode_i = 1'b1;
        repeat (4) @(negedge clk_i);
        check("reboot_pc2", 64'(pc_o), 64'(2));
        reset_n_i = 1'b0;
        #1;
        check("async_v", 64'(inst_v_o), 64'(0));
        check("async_pc", 64'(pc_o), 64'(0));
        check("async_inst", 64'(inst_o), 64'(0));
        check("async_cfg_data", 64'(cfg_data_o), 64'(0));
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check("rst_boot_fetch_v", 64'(inst_v_o), 64'(0));
        @(negedge clk_i);
        check("rst_boot_v", 64'(inst_v_o), 64'(1));
        check("rst_boot_pc", 64'(pc_o), 64'(0));
        check("rst_boot_inst", 64'(inst_o), 64'(48'hA0));
        @(negedge clk_i);
        check("rst_boot_inst1", 64'(inst_o), 64'(48'hA1));
        cce_mode_i = 1'b0;
        repeat (2) @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
